// File: rtl/pipelined_carry_adder.sv
// Pipelined carry-ripple adder: WIDTH-bit add split into STAGES slices, one slice per register
// stage, with valid/ready handshake. Define ADDER_OVERFLOW_EN to add the signed overflow output.
module pipelined_carry_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             carryout
);

    localparam int unsigned C = WIDTH / STAGES;

    logic                         advance;
    logic [STAGES-1:0]            valid_q, valid_src;
    logic [STAGES-1:0]            carry_q, carry_src, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_src, sum_d;
    logic [STAGES-1:0][WIDTH-1:0] a_src, b_src;
    logic [STAGES-1:0][C:0]       slice_w;

    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    // Index k of every *_src vector is what stage k sees as its input this cycle.
    if (STAGES == 1) begin : g_single
        assign a_src     = a;
        assign b_src     = b;
        assign valid_src = in_valid;
        assign carry_src = cin;
        assign sum_src   = '0;
    end else begin : g_multi
        logic [STAGES-2:0][WIDTH-1:0] a_q, b_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
            end else if (advance) begin
                a_q <= a_src[STAGES-2:0];
                b_q <= b_src[STAGES-2:0];
            end
        end

        assign a_src     = {a_q, a};
        assign b_src     = {b_q, b};
        assign valid_src = {valid_q[STAGES-2:0], in_valid};
        assign carry_src = {carry_q[STAGES-2:0], cin};
        assign sum_src   = {sum_q[STAGES-2:0], {WIDTH{1'b0}}};
    end

    // Stage k fills in slice k of the partial sum; lower slices ride along unchanged.
    always_comb begin
        sum_d   = sum_src;
        carry_d = '0;
        slice_w = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice_w[k] = {1'b0, a_src[k][k*C +: C]} + {1'b0, b_src[k][k*C +: C]}
                       + {{C{1'b0}}, carry_src[k]};
            sum_d[k][k*C +: C] = slice_w[k][C-1:0];
            carry_d[k]         = slice_w[k][C];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            sum_q   <= '0;
        end else if (advance) begin
            valid_q <= valid_src;
            carry_q <= carry_d;
            sum_q   <= sum_d;
        end
    end

`ifdef ADDER_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Sign bits are only needed in the last stage, where the MSB slice is formed.
    assign ovf_d = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1])
                && (sum_d[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign carryout  = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed self-checking bench for pipelined_carry_adder (WIDTH=16, STAGES=4) plus a STAGES=1
// instance sharing the same stimulus.
module tb_pipelined_carry_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic [15:0] a, b;
    logic        in_ready, out_valid, carryout;
    logic [15:0] sum;
    logic        in_ready1, out_valid1, carryout1;
    logic [15:0] sum1;
`ifdef ADDER_OVERFLOW_EN
    logic        overflow, overflow1;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipelined_carry_adder #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
`ifdef ADDER_OVERFLOW_EN
        .overflow (overflow),
`endif
        .carryout (carryout)
    );

    pipelined_carry_adder #(.WIDTH(16), .STAGES(1)) u_one (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready1),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid1),
        .out_ready(out_ready),
        .sum      (sum1),
`ifdef ADDER_OVERFLOW_EN
        .overflow (overflow1),
`endif
        .carryout (carryout1)
    );

    // Back-to-back vectors and their hand-computed results.
    logic [15:0] va [10] = '{16'h0000, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF,
                             16'h8000, 16'h1111, 16'hABCD, 16'hF0F0, 16'h7FFF};
    logic [15:0] vb [10] = '{16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF,
                             16'h8000, 16'h2222, 16'h1234, 16'h0F0F, 16'h0001};
    logic        vc [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es [10] = '{16'h0000, 16'h0010, 16'h0100, 16'h1000, 16'hFFFF,
                             16'h0000, 16'h3333, 16'hBE01, 16'h0000, 16'h8000};
    logic        ec [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic tv);
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = tv;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (2) step();
        total_cnt++;
        if ({out_valid, carryout, sum} !== 18'h0) begin
            $display("FAIL reset_outputs: got valid=%b c=%b sum=%h, want 0 0 0000",
                     out_valid, carryout, sum);
        end else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end else pass_cnt++;
        total_cnt++;
        if ({out_valid1, carryout1, sum1} !== 18'h0) begin
            $display("FAIL reset_single: got valid=%b c=%b sum=%h, want 0 0 0000",
                     out_valid1, carryout1, sum1);
        end else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        idle(6);
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        step();
        drive(16'h1234, 16'h4321, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_latency: valid=%b after 3 cycles, want 0", out_valid);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, carryout, sum} !== {1'b1, 1'b1, 16'h0000}) begin
            $display("FAIL basic_wrap: got valid=%b c=%b sum=%h, want 1 1 0000",
                     out_valid, carryout, sum);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, carryout, sum} !== {1'b1, 1'b0, 16'h5556}) begin
            $display("FAIL basic_carry: got valid=%b c=%b sum=%h, want 1 0 5556",
                     out_valid, carryout, sum);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_drain: valid=%b, want 0", out_valid);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        idle(6);
        drive(va[0], vb[0], vc[0], 1'b1);
        for (int c = 1; c <= 14; c++) begin
            step();
            total_cnt++;
            if (c < 4 || c > 13) begin
                if (out_valid !== 1'b0) begin
                    $display("FAIL b2b_idle cycle %0d: valid=%b, want 0", c, out_valid);
                end else pass_cnt++;
            end else begin
                if ({out_valid, carryout, sum} !== {1'b1, ec[c-4], es[c-4]}) begin
                    $display("FAIL b2b_result cycle %0d: got valid=%b c=%b sum=%h, want 1 %b %h",
                             c, out_valid, carryout, sum, ec[c-4], es[c-4]);
                end else pass_cnt++;
            end
            if (c < 10) drive(va[c], vb[c], vc[c], 1'b1);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        idle(6);
        out_ready = 1'b0;
        drive(16'h0001, 16'h0001, 1'b0, 1'b1);
        step();
        drive(16'h0010, 16'h0020, 1'b0, 1'b1);
        step();
        drive(16'hFFFF, 16'h0002, 1'b0, 1'b1);
        step();
        drive(16'h4000, 16'h4000, 1'b1, 1'b1);
        step();
        drive(16'h00F0, 16'h0010, 1'b0, 1'b1);
        for (int c = 4; c <= 7; c++) begin
            total_cnt++;
            if ({in_ready, out_valid, carryout, sum} !== {1'b0, 1'b1, 1'b0, 16'h0002}) begin
                $display("FAIL stall_hold cycle %0d: got rdy=%b valid=%b c=%b sum=%h, want 0 1 0 0002",
                         c, in_ready, out_valid, carryout, sum);
            end else pass_cnt++;
            if (c < 7) step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, carryout, sum} !== {1'b1, 1'b0, 16'h0030}) begin
            $display("FAIL stall_drain1: got valid=%b c=%b sum=%h, want 1 0 0030",
                     out_valid, carryout, sum);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, carryout, sum} !== {1'b1, 1'b1, 16'h0001}) begin
            $display("FAIL stall_drain2: got valid=%b c=%b sum=%h, want 1 1 0001",
                     out_valid, carryout, sum);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, carryout, sum} !== {1'b1, 1'b0, 16'h8001}) begin
            $display("FAIL stall_drain3: got valid=%b c=%b sum=%h, want 1 0 8001",
                     out_valid, carryout, sum);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, carryout, sum} !== {1'b1, 1'b0, 16'h0100}) begin
            $display("FAIL stall_drain4: got valid=%b c=%b sum=%h, want 1 0 0100",
                     out_valid, carryout, sum);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stall_empty: valid=%b, want 0", out_valid);
        end else pass_cnt++;
    endtask

`ifdef ADDER_OVERFLOW_EN
    task automatic test_overflow();
        idle(6);
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        step();
        drive(16'h8000, 16'h8000, 1'b0, 1'b1);
        step();
        drive(16'h1234, 16'h4321, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        total_cnt++;
        if ({out_valid, carryout, overflow, sum} !== {1'b1, 1'b0, 1'b1, 16'h8000}) begin
            $display("FAIL ovf_pos: got valid=%b c=%b ovf=%b sum=%h, want 1 0 1 8000",
                     out_valid, carryout, overflow, sum);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, carryout, overflow, sum} !== {1'b1, 1'b1, 1'b1, 16'h0000}) begin
            $display("FAIL ovf_neg: got valid=%b c=%b ovf=%b sum=%h, want 1 1 1 0000",
                     out_valid, carryout, overflow, sum);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, carryout, overflow, sum} !== {1'b1, 1'b0, 1'b0, 16'h5556}) begin
            $display("FAIL ovf_none: got valid=%b c=%b ovf=%b sum=%h, want 1 0 0 5556",
                     out_valid, carryout, overflow, sum);
        end else pass_cnt++;
    endtask
`endif

    task automatic test_single_stage();
        idle(6);
        drive(16'h00FF, 16'h0F01, 1'b0, 1'b1);
        step();
        total_cnt++;
        if ({out_valid1, carryout1, sum1} !== {1'b1, 1'b0, 16'h1000}) begin
            $display("FAIL single_first: got valid=%b c=%b sum=%h, want 1 0 1000",
                     out_valid1, carryout1, sum1);
        end else pass_cnt++;
        drive(16'h8000, 16'h8000, 1'b0, 1'b1);
        step();
        total_cnt++;
        if ({out_valid1, carryout1, sum1} !== {1'b1, 1'b1, 16'h0000}) begin
            $display("FAIL single_wrap: got valid=%b c=%b sum=%h, want 1 1 0000",
                     out_valid1, carryout1, sum1);
        end else pass_cnt++;
`ifdef ADDER_OVERFLOW_EN
        total_cnt++;
        if (overflow1 !== 1'b1) begin
            $display("FAIL single_ovf: got %b, want 1", overflow1);
        end else pass_cnt++;
`endif
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (out_valid1 !== 1'b0) begin
            $display("FAIL single_bubble: valid=%b, want 0", out_valid1);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        idle(6);
        drive(16'h0101, 16'h0202, 1'b0, 1'b1);
        step();
        drive(16'h1000, 16'h1000, 1'b0, 1'b1);
        step();
        drive(16'h2000, 16'h0003, 1'b1, 1'b1);
        step();
        drive(16'h0030, 16'h0040, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, carryout, sum} !== {1'b1, 1'b0, 16'h0303}) begin
            $display("FAIL rstmid_pre: got valid=%b c=%b sum=%h, want 1 0 0303",
                     out_valid, carryout, sum);
        end else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, carryout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            $display("FAIL rstmid_async: got rdy=%b valid=%b c=%b sum=%h, want 1 0 0 0000",
                     in_ready, out_valid, carryout, sum);
        end else pass_cnt++;
        step();
        rst_n = 1'b1;
        drive(16'h0FF0, 16'hF010, 1'b0, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            step();
            in_valid = 1'b0;
            total_cnt++;
            if (c == 4) begin
                if ({out_valid, carryout, sum} !== {1'b1, 1'b1, 16'h0000}) begin
                    $display("FAIL rstmid_first: got valid=%b c=%b sum=%h, want 1 1 0000",
                             out_valid, carryout, sum);
                end else pass_cnt++;
            end else begin
                if (out_valid !== 1'b0) begin
                    $display("FAIL rstmid_stale cycle %0d: valid=%b, want 0", c, out_valid);
                end else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
`ifdef ADDER_OVERFLOW_EN
        test_overflow();
`endif
        test_single_stage();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
